// File: rtl/vga_pkg.sv
// Shared VGA timing constants for 800x600@72 Hz on a 50 MHz pixel clock,
// plus the address widths that the sync source and colour consumer agree on.
package vga_pkg;

   localparam int DEF_H_ACTIVE = 800;
   localparam int DEF_H_FP     = 56;
   localparam int DEF_H_SYNC   = 120;
   localparam int DEF_H_BP     = 64;
   localparam int DEF_V_ACTIVE = 600;
   localparam int DEF_V_FP     = 37;
   localparam int DEF_V_SYNC   = 6;
   localparam int DEF_V_BP     = 23;
   localparam bit DEF_SYNC_POL = 1'b1;

   localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   localparam int COL_ADDR_W = 11;
   localparam int ROW_ADDR_W = 10;

endpackage

// File: rtl/vga_if.sv
// Sync/address bundle from the timing generator (master) to the colour
// control block (slave).
interface vga_if;
   import vga_pkg::*;

   logic                  Ready_Sig;
   logic [COL_ADDR_W-1:0] Column_Addr_Sig;
   logic [ROW_ADDR_W-1:0] Row_Addr_Sig;
   logic                  HSYNC_Sig;
   logic                  VSYNC_Sig;
   logic                  Frame_Sig;

   modport master (
      output Ready_Sig, Column_Addr_Sig, Row_Addr_Sig,
      output HSYNC_Sig, VSYNC_Sig, Frame_Sig
   );

   modport slave (
      input Ready_Sig, Column_Addr_Sig, Row_Addr_Sig,
      input HSYNC_Sig, VSYNC_Sig, Frame_Sig
   );

endinterface

// File: rtl/vga_sync_module.sv
// Free-running VGA timing generator: H/V counters, registered visible-area
// decode and coordinates, and sync pulses delayed one extra stage.
module vga_sync_module
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit SYNC_POL = DEF_SYNC_POL
) (
   input logic   CLK,
   input logic   RST_n,
   vga_if.master vga
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [COL_ADDR_W-1:0] H_LAST     = COL_ADDR_W'(H_TOTAL - 1);
   localparam logic [COL_ADDR_W-1:0] H_VISIBLE  = COL_ADDR_W'(H_ACTIVE);
   localparam logic [COL_ADDR_W-1:0] HS_FIRST   = COL_ADDR_W'(H_ACTIVE + H_FP);
   localparam logic [COL_ADDR_W-1:0] HS_LAST    = COL_ADDR_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [ROW_ADDR_W-1:0] V_LAST     = ROW_ADDR_W'(V_TOTAL - 1);
   localparam logic [ROW_ADDR_W-1:0] V_VISIBLE  = ROW_ADDR_W'(V_ACTIVE);
   localparam logic [ROW_ADDR_W-1:0] VS_FIRST   = ROW_ADDR_W'(V_ACTIVE + V_FP);
   localparam logic [ROW_ADDR_W-1:0] VS_LAST    = ROW_ADDR_W'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [COL_ADDR_W-1:0] countH_q, countH_d;
   logic [ROW_ADDR_W-1:0] countV_q, countV_d;
   logic                  ready_q, ready_d;
   logic [COL_ADDR_W-1:0] colAddr_q, colAddr_d;
   logic [ROW_ADDR_W-1:0] rowAddr_q, rowAddr_d;
   logic                  frame_q, frame_d;
   logic                  hsyncPre_q, hsyncPre_d;
   logic                  vsyncPre_q, vsyncPre_d;
   logic                  hsync_q, vsync_q;

   logic lineEnd;
   logic visible;
   logic inHsync;
   logic inVsync;

   // Next counter values and the decode of the current count; sync decode
   // feeds a pre-stage so it lines up with the consumer's colour register.
   always_comb begin
      lineEnd  = (countH_q == H_LAST);
      countH_d = lineEnd ? '0 : countH_q + COL_ADDR_W'(1);
      countV_d = countV_q;
      if (lineEnd) begin
         countV_d = (countV_q == V_LAST) ? '0 : countV_q + ROW_ADDR_W'(1);
      end

      visible = (countH_q < H_VISIBLE) && (countV_q < V_VISIBLE);
      inHsync = (countH_q >= HS_FIRST) && (countH_q <= HS_LAST);
      inVsync = (countV_q >= VS_FIRST) && (countV_q <= VS_LAST);

      ready_d    = visible;
      colAddr_d  = visible ? countH_q : '0;
      rowAddr_d  = visible ? countV_q : '0;
      frame_d    = (countH_q == '0) && (countV_q == '0);
      hsyncPre_d = inHsync ? SYNC_POL : ~SYNC_POL;
      vsyncPre_d = inVsync ? SYNC_POL : ~SYNC_POL;
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         countH_q   <= '0;
         countV_q   <= '0;
         ready_q    <= 1'b0;
         colAddr_q  <= '0;
         rowAddr_q  <= '0;
         frame_q    <= 1'b0;
         hsyncPre_q <= ~SYNC_POL;
         vsyncPre_q <= ~SYNC_POL;
         hsync_q    <= ~SYNC_POL;
         vsync_q    <= ~SYNC_POL;
      end else begin
         countH_q   <= countH_d;
         countV_q   <= countV_d;
         ready_q    <= ready_d;
         colAddr_q  <= colAddr_d;
         rowAddr_q  <= rowAddr_d;
         frame_q    <= frame_d;
         hsyncPre_q <= hsyncPre_d;
         vsyncPre_q <= vsyncPre_d;
         hsync_q    <= hsyncPre_q;
         vsync_q    <= vsyncPre_q;
      end
   end

   assign vga.Ready_Sig       = ready_q;
   assign vga.Column_Addr_Sig = colAddr_q;
   assign vga.Row_Addr_Sig    = rowAddr_q;
   assign vga.Frame_Sig       = frame_q;
   assign vga.HSYNC_Sig       = hsync_q;
   assign vga.VSYNC_Sig       = vsync_q;

endmodule

// File: tb/tb_vga_sync_module.sv
// Directed bench: default 800x600 timing (line level) and a tiny active-low
// timing set (frame level, wrap, mid-frame reset) side by side.
module tb_vga_sync_module;

   logic clk = 1'b0;
   logic rstA_n = 1'b0;
   logic rstB_n = 1'b0;

   int checks = 0;
   int errors = 0;

   int readyCnt, hsActCnt, vsActCnt, frameCnt, maxRow, lastFrameK;

   vga_if ifA ();
   vga_if ifB ();

   vga_sync_module dutA (
      .CLK   (clk),
      .RST_n (rstA_n),
      .vga   (ifA)
   );

   vga_sync_module #(
      .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
      .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
      .SYNC_POL (1'b0)
   ) dutB (
      .CLK   (clk),
      .RST_n (rstB_n),
      .vga   (ifB)
   );

   always #10 clk = ~clk;

   task automatic checkOutput(input string tag, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   task automatic getOutputs(input int sel, output int rdy, output int col, output int row,
                             output int hs, output int vs, output int fr);
      if (sel == 0) begin
         rdy = int'(ifA.Ready_Sig);  col = int'(ifA.Column_Addr_Sig); row = int'(ifA.Row_Addr_Sig);
         hs  = int'(ifA.HSYNC_Sig);  vs  = int'(ifA.VSYNC_Sig);       fr  = int'(ifA.Frame_Sig);
      end else begin
         rdy = int'(ifB.Ready_Sig);  col = int'(ifB.Column_Addr_Sig); row = int'(ifB.Row_Addr_Sig);
         hs  = int'(ifB.HSYNC_Sig);  vs  = int'(ifB.VSYNC_Sig);       fr  = int'(ifB.Frame_Sig);
      end
   endtask

   // Expected outputs k edges after reset release (k = 0 is the first edge).
   function automatic void modelOutputs(input int sel, input int k, output int rdy, output int col,
                                        output int row, output int hs, output int vs, output int fr);
      int hTot, vTot, hAct, vAct, hsLo, hsHi, vsLo, vsHi, pol;
      int h, v, hp, vp;
      if (sel == 0) begin
         hTot = 1040; vTot = 666; hAct = 800; vAct = 600;
         hsLo = 856;  hsHi = 975; vsLo = 637; vsHi = 642; pol = 1;
      end else begin
         hTot = 14; vTot = 7; hAct = 8; vAct = 4;
         hsLo = 10; hsHi = 11; vsLo = 5; vsHi = 5; pol = 0;
      end
      h   = k % hTot;
      v   = (k / hTot) % vTot;
      rdy = (h < hAct && v < vAct) ? 1 : 0;
      col = rdy ? h : 0;
      row = rdy ? v : 0;
      fr  = (h == 0 && v == 0) ? 1 : 0;
      if (k == 0) begin
         hs = 1 - pol;
         vs = 1 - pol;
      end else begin
         hp = (k - 1) % hTot;
         vp = ((k - 1) / hTot) % vTot;
         hs = (hp >= hsLo && hp <= hsHi) ? pol : 1 - pol;
         vs = (vp >= vsLo && vp <= vsHi) ? pol : 1 - pol;
      end
   endfunction

   task automatic applyStimulus(input int sel, input int nCycles);
      int rdy, col, row, hs, vs, fr;
      int eRdy, eCol, eRow, eHs, eVs, eFr;
      int pol;
      pol = (sel == 0) ? 1 : 0;
      readyCnt = 0; hsActCnt = 0; vsActCnt = 0; frameCnt = 0; maxRow = 0; lastFrameK = -1;
      for (int k = 0; k < nCycles; k++) begin
         @(posedge clk);
         #1;
         getOutputs(sel, rdy, col, row, hs, vs, fr);
         modelOutputs(sel, k, eRdy, eCol, eRow, eHs, eVs, eFr);
         checkOutput($sformatf("ready dut%0d k=%0d", sel, k), rdy, eRdy);
         checkOutput($sformatf("col dut%0d k=%0d", sel, k), col, eCol);
         checkOutput($sformatf("row dut%0d k=%0d", sel, k), row, eRow);
         checkOutput($sformatf("hsync dut%0d k=%0d", sel, k), hs, eHs);
         checkOutput($sformatf("vsync dut%0d k=%0d", sel, k), vs, eVs);
         checkOutput($sformatf("frame dut%0d k=%0d", sel, k), fr, eFr);
         if (rdy == 1) readyCnt++;
         if (rdy == 1 && row > maxRow) maxRow = row;
         if (hs == pol) hsActCnt++;
         if (vs == pol) vsActCnt++;
         if (fr == 1) begin
            frameCnt++;
            if (lastFrameK >= 0) checkOutput("frame period dut1", k - lastFrameK, 98);
            lastFrameK = k;
         end
      end
   endtask

   task automatic checkResetValues(input int sel, input string tag, input int inactive);
      int rdy, col, row, hs, vs, fr;
      getOutputs(sel, rdy, col, row, hs, vs, fr);
      checkOutput({tag, " ready"}, rdy, 0);
      checkOutput({tag, " col"},   col, 0);
      checkOutput({tag, " row"},   row, 0);
      checkOutput({tag, " hsync"}, hs,  inactive);
      checkOutput({tag, " vsync"}, vs,  inactive);
      checkOutput({tag, " frame"}, fr,  0);
   endtask

   initial begin
      int rdy, col, row, hs, vs, fr;

      $display("[TB] start");
      repeat (10) @(posedge clk);
      #1;
      checkResetValues(0, "rstA", 0);
      checkResetValues(1, "rstB", 1);

      // Default timing: three lines straight after release.
      rstA_n = 1'b1;
      applyStimulus(0, 3120);
      checkOutput("A ready count 3 lines", readyCnt, 2400);
      checkOutput("A hsync count 3 lines", hsActCnt, 360);
      checkOutput("A vsync count 3 lines", vsActCnt, 0);
      checkOutput("A frame count 3 lines", frameCnt, 1);
      checkOutput("A max row", maxRow, 2);

      // Asynchronous reset in the middle of line 3, column 399.
      repeat (400) @(posedge clk);
      #1;
      getOutputs(0, rdy, col, row, hs, vs, fr);
      checkOutput("A pre-reset ready", rdy, 1);
      checkOutput("A pre-reset col", col, 399);
      checkOutput("A pre-reset row", row, 3);
      #4;
      rstA_n = 1'b0;
      #1;
      checkResetValues(0, "A async", 0);
      repeat (3) @(posedge clk);
      #1;
      rstA_n = 1'b1;
      applyStimulus(0, 1100);
      checkOutput("A restart ready count", readyCnt, 860);

      // Small active-low timing: three whole frames, then mid-frame reset.
      rstB_n = 1'b1;
      applyStimulus(1, 294);
      checkOutput("B ready count", readyCnt, 96);
      checkOutput("B hsync count", hsActCnt, 42);
      checkOutput("B vsync count", vsActCnt, 42);
      checkOutput("B frame count", frameCnt, 3);
      checkOutput("B max row", maxRow, 3);

      repeat (34) @(posedge clk);
      #1;
      getOutputs(1, rdy, col, row, hs, vs, fr);
      checkOutput("B pre-reset ready", rdy, 1);
      checkOutput("B pre-reset col", col, 5);
      checkOutput("B pre-reset row", row, 2);
      #4;
      rstB_n = 1'b0;
      #1;
      checkResetValues(1, "B async", 1);
      repeat (2) @(posedge clk);
      #1;
      rstB_n = 1'b1;
      applyStimulus(1, 100);
      checkOutput("B restart frame count", frameCnt, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_sync_module.md
# vga_sync_module

Timing generator for the VGA output path: free-running horizontal/vertical counters for 800x600@72 Hz with a 50 MHz pixel clock. Produces HSYNC/VSYNC, the active-region qualifier `Ready_Sig` and the pixel coordinates `Column_Addr_Sig`/`Row_Addr_Sig`. A downstream colour-control module consumes the qualifier and coordinates and registers RGB one cycle later. This block is the address/sync source for that consumer and delays sync by one extra cycle so the sync pulses stay aligned with the registered colour.

## Interface
- `H_ACTIVE`, default 800: visible pixels per line
- `H_FP`, default 56: horizontal front porch, in pixels
- `H_SYNC`, default 120: HSYNC pulse width, in pixels
- `H_BP`, default 64: horizontal back porch, in pixels
- `V_ACTIVE`, default 600: visible lines per frame
- `V_FP`, default 37: vertical front porch, in lines
- `V_SYNC`, default 6: VSYNC pulse width, in lines
- `V_BP`, default 23: vertical back porch, in lines
- `SYNC_POL`, default 1: sync active level (1 = active-high)
- `CLK` input, 1 bit: 50 MHz pixel clock; the only clock
- `RST_n` input, 1 bit: reset, asynchronous, active-low
- `Ready_Sig` output, 1 bit: high while the current coordinate is inside the visible area
- `Column_Addr_Sig` output, 11 bits: pixel column, 0..H_ACTIVE-1 while Ready_Sig is high
- `Row_Addr_Sig` output, 10 bits: pixel row, 0..V_ACTIVE-1 while Ready_Sig is high
- `HSYNC_Sig` output, 1 bit: horizontal sync
- `VSYNC_Sig` output, 1 bit: vertical sync
- `Frame_Sig` output, 1 bit: one-cycle pulse on the first visible pixel (0,0) of each frame

## Operation
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 1040
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 666
- Horizontal counter `Count_H` (11 bits):
  - Increments every clock from 0 to H_TOTAL-1, then wraps to 0.
- Vertical counter `Count_V` (10 bits):
  - Increments only when Count_H wraps (Count_H == H_TOTAL-1).
  - Wraps to 0 when Count_V == V_TOTAL-1 and Count_H == H_TOTAL-1 on the same cycle.
- Line and frame order: active, front porch, sync, back porch.
  - HSYNC is active for Count_H in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [856, 975].
  - VSYNC is active for Count_V in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [637, 642]. VSYNC changes on line boundaries only.
- Visible-area decode: visible = (Count_H < H_ACTIVE) && (Count_V < V_ACTIVE). Compares are unsigned.
- Coordinate outputs:
  - While visible: Column_Addr_Sig = Count_H and Row_Addr_Sig = Count_V.
  - While not visible: both outputs are forced to 0. The downstream consumer must still gate on Ready_Sig.
- Frame_Sig is asserted when Count_H == 0 and Count_V == 0.
- Sync polarity: the active level is SYNC_POL; the inactive level is ~SYNC_POL.
- Reset (asynchronous, any time, including mid-line or mid-frame):
  - Counters go to 0.
  - Ready_Sig = 0, Column_Addr_Sig = 0, Row_Addr_Sig = 0, Frame_Sig = 0.
  - HSYNC_Sig and VSYNC_Sig go to ~SYNC_POL.
  - After release, the frame restarts from (0,0). No partial-frame recovery.

## Timing
- Counters update on the rising edge of CLK.
- Ready_Sig, Column_Addr_Sig, Row_Addr_Sig and Frame_Sig are registered decodes of the counters: latency 1 cycle from counter value to output.
- HSYNC_Sig and VSYNC_Sig pass through one extra register stage: latency 2 cycles. This matches the one-cycle colour register in the consumer, so RGB and sync arrive together at the DAC.
- First rising edge after RST_n release: counters step to (1,0), and the outputs show the decode of (0,0): Ready_Sig = 1 and Frame_Sig = 1.
- Per line: Ready_Sig is high for exactly 800 consecutive cycles and low for 240.
- Per frame: there are 600 lines containing active pixels; the line period is 1040 cycles and the frame period is 692640 cycles.
- Simultaneous wrap: at Count_H = 1039 and Count_V = 665, both counters return to 0 on the same edge.
- Frame_Sig is high for exactly 1 cycle per frame.

## Structure
- Shared package `vga_pkg`:
  - The eight timing defaults and SYNC_POL
  - Derived H_TOTAL/V_TOTAL
  - Address widths (11 for column, 10 for row) for use by the colour-control consumer
- No sub-module is needed. Counters, decode and the sync delay stage live in this block.
- Top level instantiates `vga_sync_module` feeding the colour-control module, sharing CLK and RST_n.

## Test plan
- **Reset:** hold RST_n=0 for 10 cycles -> Ready_Sig=0, both addresses 0, HSYNC_Sig=VSYNC_Sig=0 (SYNC_POL=1), Frame_Sig=0; release -> next edge Ready_Sig=1, Frame_Sig=1, Column_Addr_Sig=0, Row_Addr_Sig=0.
- **Line timing:** run 3 lines -> Ready_Sig high 800 cycles then low 240; Column_Addr_Sig runs 0..799; HSYNC_Sig high for 120 cycles starting 857 cycles after the line's first Ready_Sig cycle (856 counts + 1 extra stage).
- **Frame timing:** run 2 full frames -> Frame_Sig pulses exactly 692640 cycles apart; VSYNC_Sig high for 6×1040 = 6240 cycles; Row_Addr_Sig reaches 599 and never 600 while Ready_Sig=1.
- **Wrap boundary:** observe around the Count_H=1039, Count_V=665 transition -> next output pixel is (0,0) with Frame_Sig=1; no spurious extra line.
- **Mid-frame reset:** assert RST_n=0 asynchronously at row 300, column 400, between edges -> outputs drop to reset values immediately, without waiting for CLK; after release the frame restarts at (0,0).
- **Polarity and parameters:** SYNC_POL=0 with a small timing set (H 8/2/2/2, V 4/1/1/1) -> sync pulses active-low, positioned at H count 10..11 and V count 5, line period 14, frame period 98.
